ldh_seq_ctrl: RTL

// Control sequencer for the LDH datapath. Accepts an operand pair (A,B)

---
 rtl/ldh_seq_ctrl_if.sv | 28 ++
 rtl/ldh_seq_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/ldh_seq_ctrl_if.sv
// Operand/strobe bundle between the LDH sequencer and its requester/datapath.
// The master side drives requests and acknowledges; the sequencer is the slave.
interface ldh_seq_ctrl_if #(
    parameter int width = 8
);
    logic             start;
    logic [width-1:0] A_in;
    logic [width-1:0] B_in;
    logic             abort;
    logic             ack;
    logic             start_ready;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic             load;
    logic             busy;
    logic             readyR;
    logic [7:0]       op_count;

    modport master (
        output start, A_in, B_in, abort, ack,
        input  start_ready, A, B, load, busy, readyR, op_count
    );

    modport slave (
        input  start, A_in, B_in, abort, ack,
        output start_ready, A, B, load, busy, readyR, op_count
    );
endinterface

// File: rtl/ldh_seq_ctrl.sv
// LDH control sequencer: accepts an operand pair, then walks the datapath through
// load, a fixed-length busy phase, a settle gap and a held result-valid strobe.
module ldh_seq_ctrl #(
    parameter int width       = 8,
    parameter int BUSY_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    ldh_seq_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        READY
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUSY_CYCLES - 1);

    state_t           state_q;
    logic [width-1:0] a_q;
    logic [width-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       opCount_q;
    logic             startReady_q;
    logic             load_q;
    logic             busy_q;
    logic             readyR_q;

    // Strobes are computed for the state being entered so every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            opCount_q    <= '0;
            startReady_q <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            readyR_q     <= 1'b0;
        end else begin
            startReady_q <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            readyR_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && startReady_q) begin
                        a_q     <= bus.A_in;
                        b_q     <= bus.B_in;
                        load_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        startReady_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        startReady_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        startReady_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= GAP;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    readyR_q <= 1'b1;
                    state_q  <= READY;
                end
                READY: begin
                    if (bus.ack) begin
                        opCount_q    <= opCount_q + 8'd1;
                        startReady_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        readyR_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = startReady_q;
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.load        = load_q;
    assign bus.busy        = busy_q;
    assign bus.readyR      = readyR_q;
    assign bus.op_count    = opCount_q;
endmodule
